// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl: stage register/control inputs in,
// forwarding selects, stall/flush controls and dmem timeout flag out.
interface hazard_ctrl_if;
    logic [4:0] Rs1D, Rs2D;
    logic [4:0] Rs1E, Rs2E;
    logic [4:0] RdE, RdM, RdW;
    logic       ResultSrcE0;
    logic       RegWriteM, RegWriteW;
    logic       PCSrcE;
    logic       MemReqM;
    logic       dmem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic       mem_err;

    // Pipeline / datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, mem_err
    );

    // Hazard unit side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, mem_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage core: E-stage forwarding, load-use stall, branch flush
// and a dmem wait FSM with timeout. Optional perf counters enabled by defining HAZ_PERF_EN.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TMO_W       = 5,
    parameter int PERF_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_ctrl_if.slave      hif
`ifdef HAZ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT >= (1 << TMO_W) || PERF_W < 1) begin : g_bad_params
        $error("hazard_ctrl: MEM_TIMEOUT must be >=1 and fit in TMO_W bits; PERF_W must be >=1");
    end

    localparam logic [TMO_W-1:0] TMO = TMO_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_stall;
    logic             lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
        else                                             return 2'b00;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    // Next-state: mem_err is registered on entry to ERR so it is high during the ERR cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hif.MemReqM && !hif.dmem_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = TMO_W'(1);
                end
            end
            S_WAIT: begin
                if (hif.dmem_ready) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < TMO) begin
                    cnt_d = cnt_q + TMO_W'(1);
                end else begin
                    state_d   = S_ERR;
                    mem_err_d = 1'b1;
                end
            end
            S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE:  mem_stall = hif.MemReqM && !hif.dmem_ready;
            S_WAIT:  mem_stall = !hif.dmem_ready && (cnt_q < TMO);
            default: mem_stall = 1'b0;
        endcase

        lw_stall = hif.ResultSrcE0 && (hif.RdE != 5'd0) &&
                   ((hif.Rs1D == hif.RdE) || (hif.Rs2D == hif.RdE));

        hif.ForwardAE = '0;
        hif.ForwardBE = '0;
        hif.StallF    = 1'b0;
        hif.StallD    = 1'b0;
        hif.StallE    = 1'b0;
        hif.StallM    = 1'b0;
        hif.FlushD    = 1'b0;
        hif.FlushE    = 1'b0;
        hif.FlushW    = 1'b0;
        hif.mem_err   = mem_err_q;

        // Outputs are forced quiet while reset is held, regardless of inputs
        if (rst_n) begin
            hif.ForwardAE = fwd_sel(hif.Rs1E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
            hif.ForwardBE = fwd_sel(hif.Rs2E, hif.RdM, hif.RegWriteM, hif.RdW, hif.RegWriteW);
            if (mem_stall) begin
                hif.StallF = 1'b1;
                hif.StallD = 1'b1;
                hif.StallE = 1'b1;
                hif.StallM = 1'b1;
                hif.FlushW = 1'b1;
            end else if (hif.PCSrcE) begin
                hif.FlushD = 1'b1;
                hif.FlushE = 1'b1;
            end else if (lw_stall) begin
                hif.StallF = 1'b1;
                hif.StallD = 1'b1;
                hif.FlushE = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_EN
    logic [PERF_W-1:0] stall_cyc_q, flush_cnt_q;
    logic              any_stall;

    assign any_stall = hif.StallF | hif.StallD | hif.StallE | hif.StallM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cyc_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (any_stall && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + PERF_W'(1);
            if (hif.FlushD && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
        end
    end

    assign perf_stall_cyc = stall_cyc_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
